// File: rtl/register_read_serializer.sv
// Snapshots a WIDTH-bit register value on request and shifts it out one bit per
// accepted valid/ready beat, followed by a one-cycle completion pulse.
module register_read_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] val,
    output logic             rd_busy,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_last,
    input  logic             sdo_ready,
    output logic             rd_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] ordered;

    // Reorder the snapshot once so the beat counter always indexes from bit 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (LSB_FIRST) begin : g_lsb
                assign ordered[gi] = shadow_reg[gi];
            end else begin : g_msb
                assign ordered[gi] = shadow_reg[WIDTH-1-gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            shadow_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            shadow_reg <= shadow_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shadow_next = shadow_reg;
        count_next  = count_reg;
        rd_busy     = 1'b0;
        sdo         = 1'b0;
        sdo_valid   = 1'b0;
        sdo_last    = 1'b0;
        rd_done     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rd_req) begin
                    shadow_next = val;
                    count_next  = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                rd_busy   = 1'b1;
                sdo_valid = 1'b1;
                sdo       = ordered[count_reg];
                sdo_last  = (count_reg == LAST_COUNT);
                // Backpressure simply freezes the beat; there is no timeout.
                if (sdo_ready) begin
                    if (count_reg == LAST_COUNT) begin
                        state_next = DONE;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            DONE: begin
                rd_busy    = 1'b1;
                rd_done    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_register_read_serializer.sv
// Directed bench: drives an MSB-first and an LSB-first instance with the same
// stimulus and checks every beat against hand-computed bit sequences.
module tb_register_read_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rd_req = 1'b0;
    logic [3:0] val = 4'h0;
    logic       sdo_ready = 1'b0;

    logic m_busy, m_sdo, m_valid, m_last, m_done;
    logic l_busy, l_sdo, l_valid, l_last, l_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    register_read_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .rd_req(rd_req), .val(val),
        .rd_busy(m_busy), .sdo(m_sdo), .sdo_valid(m_valid), .sdo_last(m_last),
        .sdo_ready(sdo_ready), .rd_done(m_done)
    );

    register_read_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .rd_req(rd_req), .val(val),
        .rd_busy(l_busy), .sdo(l_sdo), .sdo_valid(l_valid), .sdo_last(l_last),
        .sdo_ready(sdo_ready), .rd_done(l_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both instances in SHIFT presenting the given bits.
    task automatic check_beat(input string tag, input logic exp_m, input logic exp_l,
                              input logic exp_last);
        chk({tag, " msb.valid"}, m_valid, 1'b1);
        chk({tag, " lsb.valid"}, l_valid, 1'b1);
        chk({tag, " msb.sdo"}, m_sdo, exp_m);
        chk({tag, " lsb.sdo"}, l_sdo, exp_l);
        chk({tag, " msb.last"}, m_last, exp_last);
        chk({tag, " lsb.last"}, l_last, exp_last);
        chk({tag, " busy"}, m_busy & l_busy, 1'b1);
        chk({tag, " done"}, m_done | l_done, 1'b0);
        $display("[TB] %s beat msb=%b lsb=%b last=%b", tag, m_sdo, l_sdo, m_last);
    endtask

    task automatic check_done(input string tag);
        chk({tag, " msb.done"}, m_done, 1'b1);
        chk({tag, " lsb.done"}, l_done, 1'b1);
        chk({tag, " done.valid"}, m_valid | l_valid, 1'b0);
        chk({tag, " done.busy"}, m_busy & l_busy, 1'b1);
        chk({tag, " done.sdo"}, m_sdo | l_sdo | m_last | l_last, 1'b0);
        $display("[TB] %s done pulse", tag);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle.busy"}, m_busy | l_busy, 1'b0);
        chk({tag, " idle.valid"}, m_valid | l_valid, 1'b0);
        chk({tag, " idle.done"}, m_done | l_done, 1'b0);
        chk({tag, " idle.sdo"}, m_sdo | l_sdo | m_last | l_last, 1'b0);
        $display("[TB] %s idle", tag);
    endtask

    initial begin
        // Reset state
        #2;
        check_idle("reset");
        step();
        step();
        reset = 1'b1;

        // 1/2: 1011 -> msb 1,0,1,1 ; lsb 1,1,0,1
        val = 4'b1011; rd_req = 1'b1; sdo_ready = 1'b1;
        step(); rd_req = 1'b0;
        check_beat("t1.b0", 1'b1, 1'b1, 1'b0);
        step(); check_beat("t1.b1", 1'b0, 1'b1, 1'b0);
        step(); check_beat("t1.b2", 1'b1, 1'b0, 1'b0);
        step(); check_beat("t1.b3", 1'b1, 1'b1, 1'b1);
        step(); check_done("t1");
        step(); check_idle("t1");

        // 3: 0110 with a 3-cycle stall at beat 2 -> 0,1,1,0 on both
        val = 4'b0110; rd_req = 1'b1;
        step(); rd_req = 1'b0;
        check_beat("t3.b0", 1'b0, 1'b0, 1'b0);
        step(); check_beat("t3.b1", 1'b1, 1'b1, 1'b0);
        sdo_ready = 1'b0;
        step(); check_beat("t3.stall0", 1'b1, 1'b1, 1'b0);
        step(); check_beat("t3.stall1", 1'b1, 1'b1, 1'b0);
        step(); check_beat("t3.stall2", 1'b1, 1'b1, 1'b0);
        sdo_ready = 1'b1;
        step(); check_beat("t3.b2", 1'b1, 1'b1, 1'b0);
        step(); check_beat("t3.b3", 1'b0, 1'b0, 1'b1);
        step(); check_done("t3");
        step(); check_idle("t3");

        // 4: val cleared and rd_req pulsed mid-transfer -> snapshot 1011 kept
        val = 4'b1011; rd_req = 1'b1;
        step(); rd_req = 1'b0; val = 4'b0000;
        check_beat("t4.b0", 1'b1, 1'b1, 1'b0);
        rd_req = 1'b1;
        step(); rd_req = 1'b0;
        check_beat("t4.b1", 1'b0, 1'b1, 1'b0);
        step(); check_beat("t4.b2", 1'b1, 1'b0, 1'b0);
        step(); check_beat("t4.b3", 1'b1, 1'b1, 1'b1);
        step(); check_done("t4");
        step(); check_idle("t4.i0");
        step(); check_idle("t4.i1");
        step(); check_idle("t4.i2");

        // 5: async reset mid-beat 2, then 1100 -> msb 1,1,0,0 ; lsb 0,0,1,1
        val = 4'b0110; rd_req = 1'b1;
        step(); rd_req = 1'b0;
        check_beat("t5.b0", 1'b0, 1'b0, 1'b0);
        step(); check_beat("t5.b1", 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 check_idle("t5.async");
        step(); check_idle("t5.held");
        reset = 1'b1;
        step(); check_idle("t5.released");
        val = 4'b1100; rd_req = 1'b1;
        step(); rd_req = 1'b0;
        check_beat("t5.b0n", 1'b1, 1'b0, 1'b0);
        step(); check_beat("t5.b1n", 1'b1, 1'b0, 1'b0);
        step(); check_beat("t5.b2n", 1'b0, 1'b1, 1'b0);
        step(); check_beat("t5.b3n", 1'b0, 1'b1, 1'b1);
        step(); check_done("t5");
        step(); check_idle("t5");

        // 6: rd_req held high -> 1010, done, one idle cycle, then captures 0101
        val = 4'b1010; rd_req = 1'b1;
        step(); val = 4'b0101;
        check_beat("t6.a0", 1'b1, 1'b0, 1'b0);
        step(); check_beat("t6.a1", 1'b0, 1'b1, 1'b0);
        step(); check_beat("t6.a2", 1'b1, 1'b0, 1'b0);
        step(); check_beat("t6.a3", 1'b0, 1'b1, 1'b1);
        step(); check_done("t6.a");
        step(); check_idle("t6.gap");
        step(); rd_req = 1'b0;
        check_beat("t6.b0", 1'b0, 1'b1, 1'b0);
        step(); check_beat("t6.b1", 1'b1, 1'b0, 1'b0);
        step(); check_beat("t6.b2", 1'b0, 1'b1, 1'b0);
        step(); check_beat("t6.b3", 1'b1, 1'b0, 1'b1);
        step(); check_done("t6.b");
        step(); check_idle("t6.end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
